// File: rtl/rr_arb_demux_if.sv
// rtl/rr_arb_demux_if.sv - Input FIFO read side and output FIFO write side of the round-robin arbiter/demux.
interface rr_arb_demux_if #(
  parameter int DATA_W = 6
);
  logic [3:0]        fifo_empty_in;
  logic [DATA_W-1:0] data_in0;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_in3;
  logic [3:0]        valid_in;
  logic [3:0]        pause_in;
  logic [3:0]        fifo_rd;
  logic [3:0]        push_out;
  logic [DATA_W-1:0] data_out;
  logic              active;
  logic              err_arb;

  // Environment side: the FIFOs around the block.
  modport master (
    output fifo_empty_in, data_in0, data_in1, data_in2, data_in3, valid_in, pause_in,
    input  fifo_rd, push_out, data_out, active, err_arb
  );

  // Arbiter side.
  modport slave (
    input  fifo_empty_in, data_in0, data_in1, data_in2, data_in3, valid_in, pause_in,
    output fifo_rd, push_out, data_out, active, err_arb
  );
endinterface

// File: rtl/rr_arb_demux.sv
// rtl/rr_arb_demux.sv - Round-robin pop of four input FIFOs, class-routed push into four output FIFOs.
module rr_arb_demux #(
  parameter int DATA_W = 6,
  parameter int NUM_CH = 4
) (
  input  logic           clk,
  input  logic           RESET,
  rr_arb_demux_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [1:0]        r_last_grant;
  logic [1:0]        r_pend_ch;
  logic              r_pend;
  logic [NUM_CH-1:0] r_push_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_err_arb;

  logic [NUM_CH-1:0] w_nonempty;
  logic              w_any_pause;
  logic              w_any_ne;
  logic              w_pop;
  logic [1:0]        w_winner;
  logic [1:0]        w_cand;
  logic              w_found;
  logic [NUM_CH-1:0] w_fifo_rd;
  logic [NUM_CH-1:0] w_pend_oh;
  logic [DATA_W-1:0] w_pend_data;
  logic              w_pend_valid;
  logic              w_err;
  logic              w_active;

  assign w_nonempty  = ~bus.fifo_empty_in;
  // Pause is global: the class of the next word is unknown until it is popped.
  assign w_any_pause = |bus.pause_in;
  assign w_any_ne    = |w_nonempty;
  assign w_pop       = !RESET && !w_any_pause && w_any_ne;

  // First non-empty channel after the last grant, wrapping back to the last grant itself.
  always_comb begin
    w_winner = r_last_grant;
    w_cand   = r_last_grant;
    w_found  = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_found && w_nonempty[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_fifo_rd = w_pop ? (NUM_CH'(1) << w_winner) : '0;

  always_comb begin
    w_pend_data = bus.data_in3;
    case (r_pend_ch)
      2'd0:    w_pend_data = bus.data_in0;
      2'd1:    w_pend_data = bus.data_in1;
      2'd2:    w_pend_data = bus.data_in2;
      default: w_pend_data = bus.data_in3;
    endcase
  end

  assign w_pend_oh    = NUM_CH'(1) << r_pend_ch;
  assign w_pend_valid = r_pend && |(bus.valid_in & w_pend_oh);
  // Missing return on the pending channel, or a return on any channel we did not pop.
  assign w_err        = (r_pend && !w_pend_valid) ||
                        |(bus.valid_in & ~(r_pend ? w_pend_oh : '0));

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_last_grant <= 2'd3;
      r_pend_ch    <= 2'd0;
      r_pend       <= 1'b0;
      r_push_out   <= '0;
      r_data_out   <= '0;
      r_err_arb    <= 1'b0;
    end else begin
      r_pend <= w_pop;
      if (w_pop) begin
        r_last_grant <= w_winner;
        r_pend_ch    <= w_winner;
      end
      if (w_pend_valid) begin
        r_data_out <= w_pend_data;
        r_push_out <= NUM_CH'(1) << w_pend_data[DATA_W-1 -: 2];
      end else begin
        r_push_out <= '0;
      end
      r_err_arb <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_next_state = S_ACTIVE;
        end else if (w_any_pause && w_any_ne) begin
          w_next_state = S_PAUSED;
        end
      end
      S_ACTIVE: begin
        if (w_any_pause && w_any_ne) begin
          w_next_state = S_PAUSED;
        end else if (!w_pop && !r_pend && !(|r_push_out)) begin
          w_next_state = S_IDLE;
        end
      end
      S_PAUSED: begin
        if (!w_any_pause && w_any_ne) begin
          w_next_state = S_ACTIVE;
        end else if (!w_any_ne) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state != S_IDLE);
  end

  assign bus.fifo_rd  = w_fifo_rd;
  assign bus.push_out = r_push_out;
  assign bus.data_out = r_data_out;
  assign bus.active   = w_active;
  assign bus.err_arb  = r_err_arb;

endmodule

// File: tb/tb_rr_arb_demux.sv
// tb/tb_rr_arb_demux.sv - Directed bench for rr_arb_demux.
module tb_rr_arb_demux;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       drop_valid = 1'b0;
  logic [3:0] spur_mask = 4'b0000;
  logic [5:0] word [4];
  int         errors = 0;
  int         checks = 0;

  rr_arb_demux_if #(.DATA_W(6)) bus();

  rr_arb_demux #(.DATA_W(6), .NUM_CH(4)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Input FIFOs return their head word one cycle after the pop strobe.
  always @(posedge clk) begin
    bus.valid_in <= (bus.fifo_rd & {4{~drop_valid}}) | spur_mask;
    bus.data_in0 <= word[0];
    bus.data_in1 <= word[1];
    bus.data_in2 <= word[2];
    bus.data_in3 <= word[3];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.fifo_empty_in = 4'b0000;
    bus.pause_in = 4'b0000;
    next_cycle();
    sample();
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL reset_rd: got %b want 0000", bus.fifo_rd); end
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL reset_push: got %b want 0000", bus.push_out); end
    checks++; if (bus.data_out !== 6'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_arb); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", bus.active); end
    next_cycle();
    sample();
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL reset_rd2: got %b want 0000", bus.fifo_rd); end
  endtask

  task automatic test_fairness();
    logic [3:0] rd_exp [5];
    logic [3:0] push_exp [5];
    rd_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    push_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0100};
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      if (c == 0) begin
        RESET = 1'b0;
        bus.fifo_empty_in = 4'b0000;
      end
      sample();
      checks++; if (bus.fifo_rd !== rd_exp[c]) begin errors++; $display("FAIL fair_rd[%0d]: got %b want %b", c, bus.fifo_rd, rd_exp[c]); end
      checks++; if (bus.push_out !== push_exp[c]) begin errors++; $display("FAIL fair_push[%0d]: got %b want %b", c, bus.push_out, push_exp[c]); end
      if (c == 1) begin
        checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL fair_active: got %b want 1", bus.active); end
      end
    end
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL fair_err: got %b want 0", bus.err_arb); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL fair_stop_rd: got %b want 0000", bus.fifo_rd); end
    checks++; if (bus.push_out !== 4'b0010) begin errors++; $display("FAIL fair_push_ch3: got %b want 0010", bus.push_out); end
    checks++; if (bus.data_out !== 6'h17) begin errors++; $display("FAIL fair_data_ch3: got %h want 17", bus.data_out); end
    next_cycle();
    sample();
    checks++; if (bus.push_out !== 4'b0001) begin errors++; $display("FAIL fair_push_last: got %b want 0001", bus.push_out); end
    checks++; if (bus.data_out !== 6'h01) begin errors++; $display("FAIL fair_data_last: got %h want 01", bus.data_out); end
    repeat (3) next_cycle();
    sample();
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b want 0", bus.active); end
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL idle_rd: got %b want 0000", bus.fifo_rd); end
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", bus.err_arb); end
  endtask

  task automatic test_class_routing();
    next_cycle();
    bus.fifo_empty_in = 4'b1011;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0100) begin errors++; $display("FAIL route_rd: got %b want 0100", bus.fifo_rd); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    sample();
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL route_push_early: got %b want 0000", bus.push_out); end
    next_cycle();
    sample();
    checks++; if (bus.push_out !== 4'b0100) begin errors++; $display("FAIL route_push: got %b want 0100", bus.push_out); end
    checks++; if (bus.data_out !== 6'h25) begin errors++; $display("FAIL route_data: got %h want 25", bus.data_out); end
    repeat (3) next_cycle();
  endtask

  task automatic test_skip_empty();
    logic [3:0] rd_exp [4];
    logic [3:0] push_exp [4];
    rd_exp   = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    push_exp = '{4'b0000, 4'b0000, 4'b0010, 4'b1000};
    next_cycle();
    bus.fifo_empty_in = 4'b1101;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0010) begin errors++; $display("FAIL skip_setup_rd: got %b want 0010", bus.fifo_rd); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    repeat (3) next_cycle();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 0) bus.fifo_empty_in = 4'b0101;
      sample();
      checks++; if (bus.fifo_rd !== rd_exp[i]) begin errors++; $display("FAIL skip_rd[%0d]: got %b want %b", i, bus.fifo_rd, rd_exp[i]); end
      checks++; if (bus.push_out !== push_exp[i]) begin errors++; $display("FAIL skip_push[%0d]: got %b want %b", i, bus.push_out, push_exp[i]); end
    end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    repeat (3) next_cycle();
  endtask

  task automatic test_pause();
    next_cycle();
    bus.fifo_empty_in = 4'b0000;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0100) begin errors++; $display("FAIL pause_first_rd: got %b want 0100", bus.fifo_rd); end
    next_cycle();
    bus.pause_in = 4'b0010;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL pause_rd_blocked: got %b want 0000", bus.fifo_rd); end
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL pause_active1: got %b want 1", bus.active); end
    next_cycle();
    sample();
    checks++; if (bus.push_out !== 4'b0100) begin errors++; $display("FAIL pause_inflight_push: got %b want 0100", bus.push_out); end
    checks++; if (bus.data_out !== 6'h25) begin errors++; $display("FAIL pause_inflight_data: got %h want 25", bus.data_out); end
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL pause_rd_held: got %b want 0000", bus.fifo_rd); end
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL pause_active2: got %b want 1", bus.active); end
    next_cycle();
    bus.pause_in = 4'b0000;
    sample();
    checks++; if (bus.fifo_rd !== 4'b1000) begin errors++; $display("FAIL pause_resume_rd: got %b want 1000", bus.fifo_rd); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    repeat (4) next_cycle();
  endtask

  task automatic test_missing_valid();
    drop_valid = 1'b1;
    next_cycle();
    bus.fifo_empty_in = 4'b1110;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0001) begin errors++; $display("FAIL miss_rd: got %b want 0001", bus.fifo_rd); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    sample();
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL miss_err_early: got %b want 0", bus.err_arb); end
    next_cycle();
    sample();
    checks++; if (bus.err_arb !== 1'b1) begin errors++; $display("FAIL miss_err: got %b want 1", bus.err_arb); end
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL miss_push: got %b want 0000", bus.push_out); end
    next_cycle();
    drop_valid = 1'b0;
    sample();
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL miss_err_pulse: got %b want 0", bus.err_arb); end
    next_cycle();
    spur_mask = 4'b0100;
    next_cycle();
    spur_mask = 4'b0000;
    next_cycle();
    sample();
    checks++; if (bus.err_arb !== 1'b1) begin errors++; $display("FAIL spur_err: got %b want 1", bus.err_arb); end
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL spur_push: got %b want 0000", bus.push_out); end
    next_cycle();
    sample();
    checks++; if (bus.err_arb !== 1'b0) begin errors++; $display("FAIL spur_err_pulse: got %b want 0", bus.err_arb); end
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.fifo_empty_in = 4'b1110;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0001) begin errors++; $display("FAIL rmid_rd: got %b want 0001", bus.fifo_rd); end
    next_cycle();
    RESET = 1'b1;
    bus.fifo_empty_in = 4'b1111;
    sample();
    checks++; if (bus.fifo_rd !== 4'b0000) begin errors++; $display("FAIL rmid_rd_in_reset: got %b want 0000", bus.fifo_rd); end
    next_cycle();
    RESET = 1'b0;
    bus.fifo_empty_in = 4'b0000;
    sample();
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL rmid_push: got %b want 0000", bus.push_out); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rmid_active: got %b want 0", bus.active); end
    checks++; if (bus.data_out !== 6'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", bus.data_out); end
    checks++; if (bus.fifo_rd !== 4'b0001) begin errors++; $display("FAIL rmid_next_grant: got %b want 0001", bus.fifo_rd); end
    next_cycle();
    bus.fifo_empty_in = 4'b1111;
    sample();
    checks++; if (bus.push_out !== 4'b0000) begin errors++; $display("FAIL rmid_push_lost: got %b want 0000", bus.push_out); end
    repeat (3) next_cycle();
  endtask

  initial begin
    word[0] = 6'h01;
    word[1] = 6'h3A;
    word[2] = 6'h25;
    word[3] = 6'h17;
    bus.fifo_empty_in = 4'b1111;
    bus.pause_in = 4'b0000;
    test_reset();
    test_fairness();
    test_class_routing();
    test_skip_empty();
    test_pause();
    test_missing_valid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
